// File: rtl/adc0809_reader.sv
// ADC0809 reader: paces conversions from a sample timer, runs the ALE/START/EOC/OE
// handshake, captures the result and flags overruns and EOC timeouts.
module adc0809_reader #(
  parameter int unsigned SAMPLE_DIV  = 200,
  parameter int unsigned ADC_CLK_DIV = 1,
  parameter int unsigned START_W     = 2,
  parameter int unsigned OE_SETUP    = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [2:0] i_chan,
  input  logic       i_eoc,
  input  logic [7:0] i_data_in,
  output logic       o_adc_clk,
  output logic [2:0] o_addr,
  output logic       o_ale,
  output logic       o_start,
  output logic       o_oe,
  output logic [7:0] o_sample,
  output logic       o_sample_valid,
  output logic       o_busy,
  output logic       o_overrun,
  output logic       o_timeout_err
);

  localparam logic [15:0] TICK_LAST  = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0] ACLK_LAST  = 16'(ADC_CLK_DIV - 1);
  localparam logic [15:0] START_LAST = 16'(START_W - 1);
  localparam logic [15:0] OE_LAST    = 16'(OE_SETUP - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StStart,
    StWaitLo,
    StWaitHi,
    StRead,
    StDone
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        w_latch_addr;
  logic        w_capture;
  logic        w_timeout;

  logic [15:0] r_aclk_cnt;
  logic        r_adc_clk;
  logic        r_eoc_meta;
  logic        r_eoc_s;
  logic [15:0] r_tick_cnt;
  logic        w_tick;
  logic [2:0]  r_addr;
  logic [7:0]  r_sample;
  logic        r_overrun;
  logic        r_timeout_err;

  // ADC conversion clock, free-running independent of i_en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aclk_cnt <= '0;
      r_adc_clk  <= 1'b0;
    end else if (r_aclk_cnt == ACLK_LAST) begin
      r_aclk_cnt <= '0;
      r_adc_clk  <= ~r_adc_clk;
    end else begin
      r_aclk_cnt <= r_aclk_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_eoc_meta <= 1'b0;
      r_eoc_s    <= 1'b0;
    end else begin
      r_eoc_meta <= i_eoc;
      r_eoc_s    <= r_eoc_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt is a per-state cycle counter, cleared on every state change.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 16'd1;
    w_latch_addr = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (w_tick && i_en) begin
          w_state_nxt  = StAddr;
          w_latch_addr = 1'b1;
        end
      end
      StAddr: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StStart;
      end
      StStart: begin
        if (r_cnt == START_LAST) begin
          w_state_nxt = StWaitLo;
          w_cnt_nxt   = '0;
        end
      end
      StWaitLo: begin
        if (!r_eoc_s) begin
          w_state_nxt = StWaitHi;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
          w_timeout   = 1'b1;
        end
      end
      StWaitHi: begin
        if (r_eoc_s) begin
          w_state_nxt = StRead;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
          w_timeout   = 1'b1;
        end
      end
      StRead: begin
        if (r_cnt == OE_LAST) begin
          w_state_nxt = StDone;
          w_cnt_nxt   = '0;
          w_capture   = 1'b1;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A tick arriving in any non-idle state, including DONE, is dropped as an overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr        <= '0;
      r_sample      <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_latch_addr) begin
        r_addr <= i_chan;
      end
      if (w_capture) begin
        r_sample <= i_data_in;
      end
      if (w_tick && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign o_adc_clk      = r_adc_clk;
  assign o_addr         = r_addr;
  assign o_ale          = (r_state == StAddr);
  assign o_start        = (r_state == StStart);
  assign o_oe           = (r_state == StRead);
  assign o_sample       = r_sample;
  assign o_sample_valid = (r_state == StDone);
  assign o_busy         = (r_state != StIdle);
  assign o_overrun      = r_overrun;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: doc/adc0809_reader.md
Name: adc0809_reader

Overview:
- Reader-side counterpart to the DAC0832 output path: drives an ADC0809 8-bit parallel ADC through its full convert/read handshake and returns samples to the design.
- Lets the generated waveform be fed back (loopback) or an external signal be digitised, for display or for frequency measurement.
- Runs in the 100 kHz system domain, generates the ADC conversion clock, paces conversions from an internal sample timer, and flags overruns and conversion timeouts.

Parameters:
- SAMPLE_DIV, 200: system-clock cycles between sample ticks (500 Sa/s at 100 kHz); legal range 2..65535.
- ADC_CLK_DIV, 1: adc_clk half-period in system cycles (1 gives 50 kHz).
- START_W, 2: START high width in system cycles.
- OE_SETUP, 2: cycles OE is held high before data_in is captured.
- TIMEOUT, 255: maximum cycles to wait on each EOC edge.

Ports:
- clk  in  1  system clock, 100 kHz
- rst_  in  1  asynchronous active-low reset
- en  in  1  enables conversions; 0 holds FSM in IDLE after the current conversion completes
- chan  in  3  analog mux channel; latched at conversion start
- eoc  in  1  ADC end-of-conversion (asynchronous)
- data_in  in  8  ADC data bus
- adc_clk  out  1  ADC conversion clock
- addr  out  3  ADDA/ADDB/ADDC
- ale  out  1  address latch enable
- start  out  1  conversion start
- oe  out  1  output enable
- sample  out  8  last captured sample
- sample_valid  out  1  one-cycle pulse when sample updates
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  sticky; set when a tick arrives while busy
- timeout_err  out  1  sticky; set on an EOC timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timers cleared. Reset mid-conversion aborts immediately and drops ale, start and oe to 0 asynchronously.
- adc_clk:
  - Toggles every ADC_CLK_DIV cycles and runs regardless of en.
- eoc synchronisation:
  - Passed through a 2-FF synchroniser; eoc_s is the synchronised signal, with 2 cycles latency.
- Sample timer:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick is high for the one cycle where count equals SAMPLE_DIV-1.
  - The timer counts even when en=0.
- FSM:
  - IDLE: on tick & en, latch chan into addr and go to ADDR. On tick & !en, nothing happens.
  - ADDR: ale=1 for 1 cycle, then go to START.
  - START: start=1 for START_W cycles (ale=0), then go to WAIT_LO.
  - WAIT_LO: wait for eoc_s=0, then go to WAIT_HI.
  - WAIT_HI: wait for eoc_s=1, then go to READ.
  - READ: oe=1 for OE_SETUP cycles; on the last of those cycles data_in is registered into sample. Then go to DONE.
  - DONE: oe=0, sample_valid=1 for exactly this cycle, then go to IDLE.
- Timeout:
  - A wait counter is cleared on entry to WAIT_LO and again on entry to WAIT_HI.
  - If it reaches TIMEOUT, set timeout_err and go to IDLE; sample is unchanged and there is no sample_valid.
- Tick while not IDLE: set overrun and ignore the tick (no queueing).
- Same-cycle events: when a tick coincides with the DONE cycle, that tick counts as overrun and is not started.
- busy equals (state != IDLE).
- addr holds its latched value until the next ADDR entry.
- chan changes mid-conversion have no effect.
- en deasserted mid-conversion: the current conversion completes normally.
- Minimum latency from tick to sample_valid: 1 (ADDR) + START_W + 2 (synchroniser, EOC fall) + 2 (synchroniser, EOC rise) + OE_SETUP + 1 (DONE), plus the ADC conversion time.
- Sticky flags clear only on reset.

Test Plan:
- ADC model with EOC falling 3 cycles after START and rising 140 cycles later, data_in=8'hA5, chan=3'd5, default parameters:
  - addr=5 at ALE.
  - sample=8'hA5 with a single-cycle sample_valid.
  - Next conversion starts exactly 200 cycles after the previous tick.
- en=0 across 3 ticks:
  - No ale or start pulse; busy stays 0.
  - Setting en=1 gives a conversion on the next tick only.
- EOC model rises 250 cycles after falling with SAMPLE_DIV=200:
  - overrun=1 at the second tick.
  - The first sample still completes with valid data.
- EOC held high permanently:
  - After 255 cycles in WAIT_LO, timeout_err=1 and the FSM returns to IDLE.
  - sample is unchanged; there is no sample_valid.
- Assert rst_ during READ (oe=1):
  - oe, busy and sample_valid go to 0 immediately.
  - After release, the next tick yields a normal conversion.
- Change chan from 2 to 7 during WAIT_HI:
  - addr stays 2 for this conversion.
  - The next conversion latches addr=7.
